// File: rtl/tcdm_bank_shim_if.sv
// Bus bundle for one TCDM bank shim: interconnect request/response channels plus the SRAM port.
// Signal names keep the shim's point of view (suffix _i = into the shim, _o = out of the shim).
interface tcdm_bank_shim_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned MetaWidth = 5
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_addr_i;
    logic                 req_wen_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [BeWidth-1:0]   req_be_i;
    logic [MetaWidth-1:0] req_meta_i;

    logic                 resp_valid_o;
    logic                 resp_ready_i;
    logic [DataWidth-1:0] resp_rdata_o;
    logic [MetaWidth-1:0] resp_meta_o;

    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [AddrWidth-1:0] mem_addr_o;
    logic [DataWidth-1:0] mem_wdata_o;
    logic [DataWidth-1:0] mem_be_o;
    logic [DataWidth-1:0] mem_rdata_i;

    // Shim side
    modport slave (
        input  req_valid_i, req_addr_i, req_wen_i, req_wdata_i, req_be_i, req_meta_i,
        output req_ready_o,
        output resp_valid_o, resp_rdata_o, resp_meta_o,
        input  resp_ready_i,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_rdata_i
    );

    // Interconnect + SRAM side
    modport master (
        output req_valid_i, req_addr_i, req_wen_i, req_wdata_i, req_be_i, req_meta_i,
        input  req_ready_o,
        input  resp_valid_o, resp_rdata_o, resp_meta_o,
        output resp_ready_i,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/tcdm_bank_shim.sv
// Per-bank adapter between the TCDM interconnect and a 1-cycle-latency single-port SRAM.
// Optional macro TCDM_SHIM_WRITE_RESP_EN: writes consume credit and return a zero-data response.
module tcdm_bank_shim #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned MetaWidth = 5,
    parameter int unsigned RespDepth = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    tcdm_bank_shim_if.slave  bus
);

    localparam int unsigned CntWidth = $clog2(RespDepth + 1);
    localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned OccWidth = CntWidth + 1;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [MetaWidth-1:0] meta;
    } resp_t;

    resp_t               r_fifo [RespDepth];
    logic [PtrWidth-1:0] r_wr_ptr;
    logic [PtrWidth-1:0] r_rd_ptr;
    logic [CntWidth-1:0] r_fifo_cnt;
    logic                r_inflight;
    logic [MetaWidth-1:0] r_meta;

    logic [OccWidth-1:0]  w_occ;
    logic                 w_credit_ok;
    logic                 w_accept;
    logic                 w_resp_issue;
    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_resp_valid;
    resp_t                w_inflight_word;
    resp_t                w_resp_word;
    logic [DataWidth-1:0] w_be_mask;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RespDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Credit counts buffered words plus the one in flight; same-cycle pops are ignored on purpose
    assign w_occ       = OccWidth'(r_fifo_cnt) + OccWidth'(r_inflight);
    assign w_credit_ok = w_occ < OccWidth'(RespDepth);

`ifdef TCDM_SHIM_WRITE_RESP_EN
    logic r_inflight_wr;

    assign bus.req_ready_o = w_credit_ok;
    assign w_resp_issue    = w_accept;
    assign w_inflight_word = '{rdata: r_inflight_wr ? '0 : bus.mem_rdata_i, meta: r_meta};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         r_inflight_wr <= 1'b0;
        else if (w_accept) r_inflight_wr <= bus.req_wen_i;
    end
`else
    assign bus.req_ready_o = bus.req_wen_i | w_credit_ok;
    assign w_resp_issue    = w_accept & ~bus.req_wen_i;
    assign w_inflight_word = '{rdata: bus.mem_rdata_i, meta: r_meta};
`endif

    assign w_accept = bus.req_valid_i & bus.req_ready_o;

    // SRAM strobes; byte enables expand to a per-bit mask
    always_comb begin
        w_be_mask = '0;
        for (int unsigned i = 0; i < BeWidth; i++) begin
            w_be_mask[i*8 +: 8] = {8{bus.req_be_i[i]}};
        end
    end

    assign bus.mem_req_o   = w_accept;
    assign bus.mem_we_o    = w_accept & bus.req_wen_i;
    assign bus.mem_addr_o  = bus.req_addr_i;
    assign bus.mem_wdata_o = bus.req_wdata_i;
    assign bus.mem_be_o    = w_be_mask;

    // Head of buffer has priority; otherwise the in-flight word bypasses straight out
    assign w_fifo_empty = (r_fifo_cnt == '0);

    always_comb begin
        w_resp_valid = 1'b0;
        w_resp_word  = '0;
        if (!w_fifo_empty) begin
            w_resp_valid = 1'b1;
            w_resp_word  = r_fifo[r_rd_ptr];
        end else if (r_inflight) begin
            w_resp_valid = 1'b1;
            w_resp_word  = w_inflight_word;
        end
    end

    assign bus.resp_valid_o = w_resp_valid;
    assign bus.resp_rdata_o = w_resp_word.rdata;
    assign bus.resp_meta_o  = w_resp_word.meta;

    assign w_push = r_inflight & ~(w_fifo_empty & bus.resp_ready_i);
    assign w_pop  = ~w_fifo_empty & bus.resp_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight <= 1'b0;
            r_meta     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            r_inflight <= w_resp_issue;
            if (w_resp_issue) r_meta <= bus.req_meta_i;
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CntWidth'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CntWidth'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_inflight_word;
    end

`ifndef SYNTHESIS
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        r_fifo_cnt <= CntWidth'(RespDepth));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && r_fifo_cnt == CntWidth'(RespDepth)));
`endif

endmodule

// File: tb/tb_tcdm_bank_shim.sv
// Self-checking bench for tcdm_bank_shim: directed scenarios plus randomized traffic vs. a queue model.
// Build with TCDM_SHIM_WRITE_RESP_EN defined to exercise the write-response variant.
module tb_tcdm_bank_shim;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned MW    = 5;
    localparam int unsigned DEPTH = 2;
`ifdef TCDM_SHIM_WRITE_RESP_EN
    localparam bit WrResp = 1'b1;
`else
    localparam bit WrResp = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic [MW-1:0] meta;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tcdm_bank_shim_if #(.DataWidth(DW), .AddrWidth(AW), .MetaWidth(MW)) bus ();

    tcdm_bank_shim #(
        .DataWidth(DW), .AddrWidth(AW), .MetaWidth(MW), .RespDepth(DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // SRAM model: single port, read data appears the cycle after the request
    logic [DW-1:0] sram    [1024];
    logic [DW-1:0] ref_mem [1024];
    always @(posedge clk) begin
        if (bus.mem_req_o) begin
            if (bus.mem_we_o)
                sram[bus.mem_addr_o] = (sram[bus.mem_addr_o] & ~bus.mem_be_o) | (bus.mem_wdata_o & bus.mem_be_o);
            else
                bus.mem_rdata_i <= sram[bus.mem_addr_o];
        end
    end

    int n_checks;
    int n_errors;
    exp_t exp_q[$];

    logic          exp_ready, exp_accept, exp_rvalid;
    logic [DW-1:0] exp_rdata, exp_mbe;
    logic [MW-1:0] exp_rmeta;
    logic          obs_ready, obs_mreq, obs_mwe, obs_rvalid;
    logic [AW-1:0] obs_maddr;
    logic [DW-1:0] obs_mwdata, obs_mbe, obs_rdata;
    logic [MW-1:0] obs_rmeta;

    task automatic drive_idle();
        bus.req_valid_i  = 1'b0;
        bus.req_wen_i    = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.req_be_i     = '0;
        bus.req_meta_i   = '0;
        bus.resp_ready_i = 1'b1;
    endtask

    // One clock: drive inputs, predict from the model, sample at negedge, advance the model at posedge
    task automatic tick(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] be, input logic [MW-1:0] m, input logic rr);
        bus.req_valid_i  = v;
        bus.req_wen_i    = w;
        bus.req_addr_i   = a;
        bus.req_wdata_i  = d;
        bus.req_be_i     = be;
        bus.req_meta_i   = m;
        bus.resp_ready_i = rr;
        exp_ready  = (w && !WrResp) ? 1'b1 : (exp_q.size() < DEPTH);
        exp_accept = v && exp_ready;
        exp_rvalid = exp_q.size() > 0;
        exp_rdata  = exp_rvalid ? exp_q[0].rdata : '0;
        exp_rmeta  = exp_rvalid ? exp_q[0].meta : '0;
        for (int i = 0; i < 4; i++) exp_mbe[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
        @(negedge clk);
        obs_ready  = bus.req_ready_o;
        obs_mreq   = bus.mem_req_o;
        obs_mwe    = bus.mem_we_o;
        obs_maddr  = bus.mem_addr_o;
        obs_mwdata = bus.mem_wdata_o;
        obs_mbe    = bus.mem_be_o;
        obs_rvalid = bus.resp_valid_o;
        obs_rdata  = bus.resp_rdata_o;
        obs_rmeta  = bus.resp_meta_o;
        @(posedge clk);
        if (exp_rvalid && rr) void'(exp_q.pop_front());
        if (exp_accept) begin
            if (!w) begin
                exp_q.push_back('{rdata: ref_mem[a], meta: m});
            end else begin
                for (int i = 0; i < 4; i++) if (be[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
                if (WrResp) exp_q.push_back('{rdata: '0, meta: m});
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 10'h3;
        #2;
        n_checks++;
        if ({bus.req_ready_o, bus.mem_req_o, bus.resp_valid_o} !== 3'b110) begin
            n_errors++;
            $display("FAIL reset_ctrl: got ready/mreq/rvalid=%b expected 110",
                     {bus.req_ready_o, bus.mem_req_o, bus.resp_valid_o});
        end
        n_checks++;
        if ({bus.resp_rdata_o, bus.resp_meta_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_resp_zero: got rdata=%h meta=%h expected 0", bus.resp_rdata_o, bus.resp_meta_o);
        end
        repeat (2) @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_first_read();
        sram[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        tick(1'b1, 1'b0, 10'h004, '0, 4'h0, 5'd3, 1'b1);
        n_checks++;
        if ({obs_ready, obs_mreq, obs_mwe, obs_rvalid} !== 4'b1100) begin
            n_errors++;
            $display("FAIL first_read_issue: got ready/mreq/mwe/rvalid=%b expected 1100",
                     {obs_ready, obs_mreq, obs_mwe, obs_rvalid});
        end
        tick(1'b0, 1'b0, '0, '0, 4'h0, '0, 1'b1);
        n_checks++;
        if ({obs_ready, obs_rvalid, obs_rdata, obs_rmeta} !== {1'b1, 1'b1, 32'hDEADBEEF, 5'd3}) begin
            n_errors++;
            $display("FAIL first_read_resp: got ready=%b valid=%b rdata=%h meta=%0d expected 1 1 deadbeef 3",
                     obs_ready, obs_rvalid, obs_rdata, obs_rmeta);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [4];
        for (int i = 1; i <= 3; i++) begin
            vals[i] = $urandom;
            sram[i] = vals[i];
            ref_mem[i] = vals[i];
        end
        for (int k = 0; k <= 4; k++) begin
            tick(k < 3, 1'b0, AW'(k + 1), '0, 4'h0, MW'(k + 1), 1'b1);
            if (k < 3) begin
                n_checks++;
                if (obs_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_ready[%0d]: got %b expected 1", k, obs_ready);
                end
            end
            if (k >= 1 && k <= 3) begin
                n_checks++;
                if ({obs_rvalid, obs_rmeta, obs_rdata} !== {1'b1, MW'(k), vals[k]}) begin
                    n_errors++;
                    $display("FAIL b2b_resp[%0d]: got valid=%b meta=%0d rdata=%h expected 1 %0d %h",
                             k, obs_rvalid, obs_rmeta, obs_rdata, k, vals[k]);
                end
            end else if (k == 4) begin
                n_checks++;
                if (obs_rvalid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_idle: got valid=%b expected 0", obs_rvalid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] vals [3];
        logic          rdy_exp [7];
        logic [MW-1:0] meta_exp [7];
        rdy_exp  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        meta_exp = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd0};
        for (int i = 0; i < 3; i++) begin
            vals[i] = $urandom;
            sram[8 + i] = vals[i];
            ref_mem[8 + i] = vals[i];
        end
        tick(1'b1, 1'b0, 10'd8,  '0, 4'h0, 5'd1, 1'b0);
        n_checks++;
        if (obs_ready !== rdy_exp[0]) begin
            n_errors++; $display("FAIL bp_ready[0]: got %b expected %b", obs_ready, rdy_exp[0]);
        end
        for (int c = 1; c < 7; c++) begin
            if (c == 1)      tick(1'b1, 1'b0, 10'd9,  '0, 4'h0, 5'd2, 1'b0);
            else if (c == 2) tick(1'b1, 1'b0, 10'd10, '0, 4'h0, 5'd3, 1'b0);
            else if (c <= 4) tick(1'b1, 1'b0, 10'd10, '0, 4'h0, 5'd3, 1'b1);
            else             tick(1'b0, 1'b0, '0,     '0, 4'h0, 5'd0, 1'b1);
            if (c <= 4) begin
                n_checks++;
                if (obs_ready !== rdy_exp[c]) begin
                    n_errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", c, obs_ready, rdy_exp[c]);
                end
            end
            n_checks++;
            if ({obs_rvalid, obs_rmeta} !== {c < 6, meta_exp[c]}) begin
                n_errors++;
                $display("FAIL bp_resp[%0d]: got valid=%b meta=%0d expected %b %0d",
                         c, obs_rvalid, obs_rmeta, c < 6, meta_exp[c]);
            end
            if (c >= 3 && c <= 5) begin
                n_checks++;
                if (obs_rdata !== vals[c - 3]) begin
                    n_errors++; $display("FAIL bp_rdata[%0d]: got %h expected %h", c, obs_rdata, vals[c - 3]);
                end
            end
        end
    endtask

    task automatic test_write_mask();
        sram[5] = 32'hAABBCCDD;
        ref_mem[5] = 32'hAABBCCDD;
        tick(1'b1, 1'b1, 10'd5, 32'h12345678, 4'b0011, 5'd4, 1'b1);
        n_checks++;
        if ({obs_ready, obs_mreq, obs_mwe, obs_mbe, obs_mwdata} !== {3'b111, 32'h0000FFFF, 32'h12345678}) begin
            n_errors++;
            $display("FAIL wr_strobes: got ready/mreq/mwe=%b be=%h wdata=%h expected 111 0000ffff 12345678",
                     {obs_ready, obs_mreq, obs_mwe}, obs_mbe, obs_mwdata);
        end
        tick(1'b1, 1'b0, 10'd5, '0, 4'h0, 5'd9, 1'b1);
        n_checks++;
        if ({obs_rvalid, obs_rmeta, obs_rdata} !== (WrResp ? {1'b1, 5'd4, 32'h0} : {1'b0, 5'd0, 32'h0})) begin
            n_errors++;
            $display("FAIL wr_resp: got valid=%b meta=%0d rdata=%h expected write response %b",
                     obs_rvalid, obs_rmeta, obs_rdata, WrResp);
        end
        tick(1'b0, 1'b0, '0, '0, 4'h0, '0, 1'b1);
        n_checks++;
        if ({obs_rvalid, obs_rmeta, obs_rdata} !== {1'b1, 5'd9, 32'hAABB5678}) begin
            n_errors++;
            $display("FAIL wr_readback: got valid=%b meta=%0d rdata=%h expected 1 9 aabb5678",
                     obs_rvalid, obs_rmeta, obs_rdata);
        end
    endtask

`ifdef TCDM_SHIM_WRITE_RESP_EN
    task automatic test_write_resp();
        tick(1'b1, 1'b1, 10'd6, 32'hCAFEF00D, 4'hF, 5'd7, 1'b0);
        tick(1'b1, 1'b0, 10'd7, '0, 4'h0, 5'd8, 1'b0);
        n_checks++;
        if ({obs_ready, obs_rvalid, obs_rmeta, obs_rdata} !== {2'b11, 5'd7, 32'h0}) begin
            n_errors++;
            $display("FAIL wresp_read_accept: got ready=%b valid=%b meta=%0d rdata=%h expected 1 1 7 0",
                     obs_ready, obs_rvalid, obs_rmeta, obs_rdata);
        end
        tick(1'b1, 1'b0, 10'd7, '0, 4'h0, 5'd9, 1'b0);
        n_checks++;
        if (obs_ready !== 1'b0) begin
            n_errors++; $display("FAIL wresp_stall: got ready=%b expected 0", obs_ready);
        end
        tick(1'b0, 1'b0, '0, '0, 4'h0, '0, 1'b1);
        n_checks++;
        if ({obs_rvalid, obs_rmeta, obs_rdata} !== {1'b1, 5'd7, 32'h0}) begin
            n_errors++;
            $display("FAIL wresp_first: got valid=%b meta=%0d rdata=%h expected 1 7 0", obs_rvalid, obs_rmeta, obs_rdata);
        end
        tick(1'b0, 1'b0, '0, '0, 4'h0, '0, 1'b1);
        n_checks++;
        if ({obs_rvalid, obs_rmeta, obs_rdata} !== {1'b1, 5'd8, ref_mem[7]}) begin
            n_errors++;
            $display("FAIL wresp_second: got valid=%b meta=%0d rdata=%h expected 1 8 %h",
                     obs_rvalid, obs_rmeta, obs_rdata, ref_mem[7]);
        end
    endtask
`endif

    task automatic test_reset_midop();
        tick(1'b1, 1'b0, 10'd1, '0, 4'h0, 5'd11, 1'b0);
        tick(1'b1, 1'b0, 10'd2, '0, 4'h0, 5'd12, 1'b0);
        drive_idle();
        rst = 1'b1;
        #1;
        exp_q.delete();
        n_checks++;
        if ({bus.resp_valid_o, bus.req_ready_o} !== 2'b01) begin
            n_errors++;
            $display("FAIL midop_reset_now: got valid/ready=%b expected 01", {bus.resp_valid_o, bus.req_ready_o});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, '0, '0, 4'h0, '0, 1'b1);
            n_checks++;
            if ({obs_rvalid, obs_rmeta, obs_rdata, obs_ready} !== {1'b0, 5'd0, 32'h0, 1'b1}) begin
                n_errors++;
                $display("FAIL midop_after[%0d]: got valid=%b meta=%0d rdata=%h ready=%b expected 0 0 0 1",
                         k, obs_rvalid, obs_rmeta, obs_rdata, obs_ready);
            end
        end
    endtask

    task automatic test_random();
        int stall_bias;
        for (int k = 0; k < 600; k++) begin
            stall_bias = (k / 100) % 2 == 1 ? 3 : 1;
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, AW'($urandom_range(0, 15)), $urandom,
                 4'($urandom_range(0, 15)), MW'($urandom_range(0, 31)),
                 $urandom_range(0, stall_bias) == 0);
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", k, obs_ready, exp_ready);
            end
            n_checks++;
            if ({obs_mreq, obs_mwe} !== {exp_accept, exp_accept && bus.req_wen_i}) begin
                n_errors++;
                $display("FAIL rnd_mem_strobe[%0d]: got req/we=%b%b expected %b%b", k, obs_mreq, obs_mwe,
                         exp_accept, exp_accept && bus.req_wen_i);
            end
            n_checks++;
            if ({obs_maddr, obs_mwdata, obs_mbe} !== {bus.req_addr_i, bus.req_wdata_i, exp_mbe}) begin
                n_errors++;
                $display("FAIL rnd_mem_bus[%0d]: got addr=%h wdata=%h be=%h expected %h %h %h", k,
                         obs_maddr, obs_mwdata, obs_mbe, bus.req_addr_i, bus.req_wdata_i, exp_mbe);
            end
            n_checks++;
            if ({obs_rvalid, obs_rmeta, obs_rdata} !== {exp_rvalid, exp_rmeta, exp_rdata}) begin
                n_errors++;
                $display("FAIL rnd_resp[%0d]: got valid=%b meta=%0d rdata=%h expected %b %0d %h", k,
                         obs_rvalid, obs_rmeta, obs_rdata, exp_rvalid, exp_rmeta, exp_rdata);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, '0, '0, 4'h0, '0, 1'b1);
            n_checks++;
            if ({obs_rvalid, obs_rmeta, obs_rdata} !== {exp_rvalid, exp_rmeta, exp_rdata}) begin
                n_errors++;
                $display("FAIL rnd_drain[%0d]: got valid=%b meta=%0d rdata=%h expected %b %0d %h", k,
                         obs_rvalid, obs_rmeta, obs_rdata, exp_rvalid, exp_rmeta, exp_rdata);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 1024; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        test_reset();
        test_first_read();
        test_back_to_back();
        test_backpressure();
        test_write_mask();
`ifdef TCDM_SHIM_WRITE_RESP_EN
        test_write_resp();
`endif
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
